// File: rtl/ula_multiciclo_pkg.sv
// Shared op codes and FSM encoding for the multicycle RV64 ALU.
package ula_multiciclo_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_OR     = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_SLT    = 4'd5;
  localparam logic [3:0] OP_SLTU   = 4'd6;
  localparam logic [3:0] OP_RSVD   = 4'd7;
  localparam logic [3:0] OP_MUL    = 4'd8;
  localparam logic [3:0] OP_MULH   = 4'd9;
  localparam logic [3:0] OP_MULHSU = 4'd10;
  localparam logic [3:0] OP_MULHU  = 4'd11;
  localparam logic [3:0] OP_DIV    = 4'd12;
  localparam logic [3:0] OP_DIVU   = 4'd13;
  localparam logic [3:0] OP_REM    = 4'd14;
  localparam logic [3:0] OP_REMU   = 4'd15;

  typedef enum logic [2:0] {StOcioso, StPrepara, StCalcula, StAjusta, StFim} state_e;

endpackage

// File: rtl/ula_multiciclo_if.sv
// Control-unit <-> ALU handshake and operand bus.
interface ula_multiciclo_if #(
  parameter int unsigned BITS = 64
);
  logic            inicio;
  logic [BITS-1:0] dina;
  logic [BITS-1:0] dinb;
  logic [BITS-1:0] imm;
  logic            alu_src;
  logic [3:0]      operacao;
  logic [BITS-1:0] dout;
  logic            pronto;
  logic            ocupado;
  logic            flag_igual;
  logic            flag_menor;
  logic            flag_maior_igual_u;

  modport master (
    output inicio, dina, dinb, imm, alu_src, operacao,
    input  dout, pronto, ocupado, flag_igual, flag_menor, flag_maior_igual_u
  );

  modport slave (
    input  inicio, dina, dinb, imm, alu_src, operacao,
    output dout, pronto, ocupado, flag_igual, flag_menor, flag_maior_igual_u
  );
endinterface

// File: rtl/ula_multiciclo_mul_div_iterativo.sv
// Radix-2 unsigned core: shift-add multiply or restoring divide, one bit per step.
module mul_div_iterativo #(
  parameter int unsigned BITS = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            is_div_i,
  input  logic [BITS-1:0] a_mag_i,
  input  logic [BITS-1:0] b_mag_i,
  output logic [BITS-1:0] hi_o,
  output logic [BITS-1:0] lo_o
);

  // hi: upper product / partial remainder; lo: multiplier / dividend shifting into quotient
  logic [BITS-1:0] hi_q, hi_d, lo_q, lo_d, b_q;
  logic [BITS:0]   mul_sum, div_sh;
  logic            div_ge;

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_sh  = {hi_q, lo_q[BITS-1]};
    div_ge  = div_sh >= {1'b0, b_q};
    if (is_div_i) begin
      hi_d = div_ge ? (div_sh[BITS-1:0] - b_q) : div_sh[BITS-1:0];
      lo_d = {lo_q[BITS-2:0], div_ge};
    end else begin
      hi_d = mul_sum[BITS:1];
      lo_d = {mul_sum[0], lo_q[BITS-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
    end else if (load_i) begin
      hi_q <= '0;
      lo_q <= a_mag_i;
      b_q  <= b_mag_i;
    end else if (step_i) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/ula_multiciclo.sv
// RV64 ALU: single-cycle base ops plus iterative RV64M multiply/divide behind a start/busy handshake.
module ula_multiciclo #(
  parameter int unsigned BITS = 64
) (
  input logic            clk,
  input logic            reset,
  ula_multiciclo_if.slave bus
);
  import ula_multiciclo_pkg::*;

  localparam int unsigned CntW = $clog2(BITS);

  state_e            state_q, state_d;
  logic [BITS-1:0]   a_q, b_q, dout_q, alu_res, md_res, op_b, a_mag, b_mag, hi, lo;
  logic [3:0]        op_q;
  logic [2:0]        flags_now, flags_pend_q, flags_q;
  logic [CntW-1:0]   cnt_q;
  logic              neg_q, neg_d, sub, slt, sltu, a_signed, b_signed, a_neg, b_neg, accept;
  logic [BITS:0]     sum;
  logic [2*BITS-1:0] prod_s;

  assign accept = (state_q == StOcioso) && bus.inicio;

  // Single-cycle datapath works straight off the bus so the result lands with the FIM entry
  always_comb begin
    op_b = bus.alu_src ? bus.imm : bus.dinb;
    sub  = bus.operacao != OP_ADD;
    sum  = {1'b0, bus.dina} + {1'b0, op_b ^ {BITS{sub}}} + {{BITS{1'b0}}, sub};
    sltu = ~sum[BITS];
    slt  = (bus.dina[BITS-1] != op_b[BITS-1]) ? bus.dina[BITS-1] : sum[BITS-1];
    case (bus.operacao)
      OP_ADD, OP_SUB: alu_res = sum[BITS-1:0];
      OP_AND:         alu_res = bus.dina & op_b;
      OP_OR:          alu_res = bus.dina | op_b;
      OP_XOR:         alu_res = bus.dina ^ op_b;
      OP_SLT:         alu_res = {{(BITS-1){1'b0}}, slt};
      OP_SLTU:        alu_res = {{(BITS-1){1'b0}}, sltu};
      default:        alu_res = '0;
    endcase
    flags_now = {bus.dina == bus.dinb, $signed(bus.dina) < $signed(bus.dinb),
                 bus.dina >= bus.dinb};
  end

  always_comb begin
    a_signed = op_q inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed = op_q inside {OP_MULH, OP_DIV, OP_REM};
    a_neg    = a_signed & a_q[BITS-1];
    b_neg    = b_signed & b_q[BITS-1];
    a_mag    = a_neg ? -a_q : a_q;
    b_mag    = b_neg ? -b_q : b_q;
    // Divide by zero must yield all ones, so the quotient is never negated then
    if (op_q == OP_DIV)          neg_d = (a_neg ^ b_neg) & (b_q != '0);
    else if (op_q[3:1] == 3'b111) neg_d = a_neg;
    else                          neg_d = a_neg ^ b_neg;
    prod_s = neg_q ? -{hi, lo} : {hi, lo};
    case (op_q)
      OP_MUL:                      md_res = prod_s[BITS-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: md_res = prod_s[2*BITS-1:BITS];
      OP_DIV, OP_DIVU:             md_res = neg_q ? -lo : lo;
      default:                     md_res = neg_q ? -hi : hi;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StOcioso:  if (bus.inicio) state_d = bus.operacao[3] ? StPrepara : StFim;
      StPrepara: state_d = StCalcula;
      StCalcula: if (cnt_q == CntW'(BITS - 1)) state_d = StAjusta;
      StAjusta:  state_d = StFim;
      StFim:     state_d = StOcioso;
      default:   state_d = StOcioso;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StOcioso;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      neg_q        <= 1'b0;
      cnt_q        <= '0;
      flags_pend_q <= '0;
      flags_q      <= '0;
      dout_q       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q          <= bus.dina;
        b_q          <= op_b;
        op_q         <= bus.operacao;
        flags_pend_q <= flags_now;
        if (!bus.operacao[3]) begin
          dout_q  <= alu_res;
          flags_q <= flags_now;
        end
      end
      if (state_q == StPrepara) begin
        neg_q <= neg_d;
        cnt_q <= '0;
      end
      if (state_q == StCalcula) cnt_q <= cnt_q + 1'b1;
      if (state_q == StAjusta) begin
        dout_q  <= md_res;
        flags_q <= flags_pend_q;
      end
    end
  end

  mul_div_iterativo #(
    .BITS(BITS)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .load_i  (state_q == StPrepara),
    .step_i  (state_q == StCalcula),
    .is_div_i(op_q[2]),
    .a_mag_i (a_mag),
    .b_mag_i (b_mag),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  assign bus.dout               = dout_q;
  assign bus.pronto             = state_q == StFim;
  assign bus.ocupado            = state_q != StOcioso;
  assign bus.flag_igual         = flags_q[2];
  assign bus.flag_menor         = flags_q[1];
  assign bus.flag_maior_igual_u = flags_q[0];

endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed bench for ula_multiciclo with a cycle-level reference model and literal spot checks.
module tb_ula_multiciclo;
  localparam int BITS = 64;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  ula_multiciclo_if #(.BITS(BITS)) bus ();

  ula_multiciclo #(.BITS(BITS)) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [63:0] model_res(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
    logic signed [127:0] ps;
    logic [127:0]        pu;
    logic signed [63:0]  sa, sb;
    logic                ovf;
    sa  = a;
    sb  = b;
    ovf = (a == MINV) && (b == ONES);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return (sa < sb) ? 64'd1 : 64'd0;
      4'd6:  return (a < b) ? 64'd1 : 64'd0;
      4'd8:  return a * b;
      4'd9: begin
        ps = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
        return ps[127:64];
      end
      4'd10: begin
        ps = $signed({{64{a[63]}}, a}) * $signed({64'd0, b});
        return ps[127:64];
      end
      4'd11: begin
        pu = {64'd0, a} * {64'd0, b};
        return pu[127:64];
      end
      4'd12: return (b == 0) ? ONES : ovf ? a : 64'(sa / sb);
      4'd13: return (b == 0) ? ONES : a / b;
      4'd14: return (b == 0) ? a : ovf ? 64'd0 : 64'(sa % sb);
      4'd15: return (b == 0) ? a : a % b;
      default: return 64'd0;
    endcase
  endfunction

  // Reference model state: what the outputs must show in each cycle
  int          cyc = 0;
  int          start_cyc = -10;
  int          end_cyc = -10;
  logic [63:0] pend_dout = '0, shown_dout = '0;
  logic [2:0]  pend_fl = '0, shown_fl = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      start_cyc  = -10;
      end_cyc    = -10;
      shown_dout = '0;
      shown_fl   = '0;
    end else begin
      cyc++;
      if (bus.inicio && cyc >= end_cyc + 2) begin
        pend_dout = model_res(bus.operacao, bus.dina, bus.alu_src ? bus.imm : bus.dinb);
        pend_fl   = {bus.dina == bus.dinb, $signed(bus.dina) < $signed(bus.dinb),
                     bus.dina >= bus.dinb};
        start_cyc = cyc;
        end_cyc   = cyc + (bus.operacao[3] ? BITS + 3 : 1) - 1;
      end
      if (cyc == end_cyc) begin
        shown_dout = pend_dout;
        shown_fl   = pend_fl;
      end
    end
  end

  always @(negedge clk) begin
    check("pronto", 64'(bus.pronto), 64'(cyc == end_cyc));
    check("ocupado", 64'(bus.ocupado), 64'(cyc >= start_cyc && cyc <= end_cyc));
    check("dout", bus.dout, shown_dout);
    check("flags", 64'({bus.flag_igual, bus.flag_menor, bus.flag_maior_igual_u}),
          64'(shown_fl));
  end

  task automatic run_op(input string name, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] imm, input logic src,
                        input logic [63:0] lit, input int lat, input int glitch_at);
    int n;
    @(negedge clk);
    bus.operacao = op;
    bus.dina     = a;
    bus.dinb     = b;
    bus.imm      = imm;
    bus.alu_src  = src;
    bus.inicio   = 1'b1;
    n = 0;
    while (n < 150) begin
      @(negedge clk);
      n++;
      if (bus.pronto) break;
      // Operands were latched; scribble over them to prove it
      bus.inicio   = (n == glitch_at);
      bus.operacao = 4'd0;
      bus.dina     = 64'($urandom);
      bus.dinb     = 64'($urandom);
      bus.imm      = 64'($urandom);
    end
    bus.inicio = 1'b0;
    check({name, "_latency"}, 64'(n), 64'(lat));
    check({name, "_value"}, bus.dout, lit);
  endtask

  initial begin
    bus.inicio   = 1'b0;
    bus.dina     = '0;
    bus.dinb     = '0;
    bus.imm      = '0;
    bus.alu_src  = 1'b0;
    bus.operacao = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_dout", bus.dout, 64'd0);
    check("reset_ocupado", 64'(bus.ocupado), 64'd0);
    #2 rst = 1'b0;

    run_op("add_imm", 4'd0, 64'd5, 64'd10, -64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0);
    check("add_imm_menor", 64'(bus.flag_menor), 64'd1);
    run_op("sub", 4'd1, 64'd10, 64'd3, 64'd0, 1'b0, 64'd7, 1, 0);
    run_op("and", 4'd2, 64'hF0F0, 64'hFF00, 64'd0, 1'b0, 64'hF000, 1, 0);
    run_op("or", 4'd3, 64'hF0F0, 64'hFF00, 64'd0, 1'b0, 64'hFFF0, 1, 0);
    run_op("xor", 4'd4, 64'hF0F0, 64'hFF00, 64'd0, 1'b0, 64'h0FF0, 1, 0);
    run_op("slt", 4'd5, ONES, 64'd1, 64'd0, 1'b0, 64'd1, 1, 0);
    run_op("sltu", 4'd6, ONES, 64'd1, 64'd0, 1'b0, 64'd0, 1, 0);
    run_op("rsvd", 4'd7, 64'd3, 64'd4, 64'd0, 1'b0, 64'd0, 1, 0);
    run_op("eqflag", 4'd0, 64'd9, 64'd9, 64'd0, 1'b0, 64'd18, 1, 0);
    check("eqflag_igual", 64'(bus.flag_igual), 64'd1);

    run_op("mul", 4'd8, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd0, 1'b0,
           64'hFFFF_FFFE_0000_0001, 67, 0);
    run_op("mulhu", 4'd11, ONES, ONES, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 67, 0);
    run_op("mulh", 4'd9, ONES, ONES, 64'd0, 1'b0, 64'd0, 67, 0);
    run_op("mulhsu", 4'd10, ONES, ONES, 64'd0, 1'b0, ONES, 67, 0);
    run_op("div", 4'd12, -64'd7, 64'd2, 64'd0, 1'b0, -64'd3, 67, 0);
    run_op("rem", 4'd14, -64'd7, 64'd2, 64'd0, 1'b0, ONES, 67, 0);
    run_op("divu0", 4'd13, 64'd7, 64'd0, 64'd0, 1'b0, ONES, 67, 0);
    run_op("remu0", 4'd15, 64'd7, 64'd0, 64'd0, 1'b0, 64'd7, 67, 0);
    run_op("div0", 4'd12, -64'd7, 64'd0, 64'd0, 1'b0, ONES, 67, 0);
    run_op("rem0", 4'd14, -64'd7, 64'd0, 64'd0, 1'b0, -64'd7, 67, 0);
    run_op("div_ovf", 4'd12, MINV, ONES, 64'd0, 1'b0, MINV, 67, 0);
    run_op("rem_ovf", 4'd14, MINV, ONES, 64'd0, 1'b0, 64'd0, 67, 0);
    run_op("divu", 4'd13, 64'd100, 64'd7, 64'd0, 1'b0, 64'd14, 67, 0);
    run_op("div_busy", 4'd12, 64'd100, -64'd7, 64'd0, 1'b0, -64'd14, 67, 10);

    // Reset mid-multiply: outputs clear immediately and the op never completes
    @(negedge clk);
    bus.operacao = 4'd8;
    bus.dina     = 64'd3;
    bus.dinb     = 64'd5;
    bus.alu_src  = 1'b0;
    bus.inicio   = 1'b1;
    @(negedge clk);
    bus.inicio = 1'b0;
    repeat (29) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_dout", bus.dout, 64'd0);
    check("midrst_ocupado", 64'(bus.ocupado), 64'd0);
    check("midrst_pronto", 64'(bus.pronto), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (70) @(negedge clk);
    run_op("add_after", 4'd0, 64'd40, 64'd2, 64'd0, 1'b0, 64'd42, 1, 0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
